// File: rtl/proc_pkg.sv
// Shared definitions for the processor controller: widths, opcodes,
// state encodings, ALU select codes and instruction field positions.
package proc_pkg;

    localparam int IR_W      = 16;
    localparam int D_ADDR_W  = 8;
    localparam int RF_ADDR_W = 4;
    localparam int ALU_SEL_W = 3;
    localparam int STATE_W   = 4;

    // Instruction field bit positions
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RA_MSB = 11;
    localparam int RA_LSB = 8;
    localparam int RB_MSB = 7;
    localparam int RB_LSB = 4;
    localparam int RW_MSB = 3;
    localparam int RW_LSB = 0;
    localparam int DA_MSB = 7;
    localparam int DA_LSB = 0;

    // Opcodes (6..15 behave as NOOP)
    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    // ALU function selects
    localparam logic [ALU_SEL_W-1:0] ALU_PASS = 3'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 3'd2;

    // Controller states; codes 10..15 are unused and recover to Init
    typedef enum logic [STATE_W-1:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

endpackage

// File: rtl/processor_controller_if.sv
// Control bus between the controller (master) and the datapath (slave).
// There is no handshake: the controller issues level enables/selects each
// cycle from its current state, and the datapath returns the IR contents.
interface proc_ctrl_if;
    import proc_pkg::*;

    logic [IR_W-1:0]      IR;
    logic                 PC_Clr;
    logic                 PC_Up;
    logic                 IR_Ld;
    logic [D_ADDR_W-1:0]  D_Addr;
    logic                 D_Wr;
    logic                 RF_s;
    logic [RF_ADDR_W-1:0] RF_W_Addr;
    logic                 RF_W_en;
    logic [RF_ADDR_W-1:0] RF_Ra_Addr;
    logic [RF_ADDR_W-1:0] RF_Rb_Addr;
    logic [ALU_SEL_W-1:0] ALU_s0;

    modport master (
        input  IR,
        output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr,
               RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0
    );

    modport slave (
        output IR,
        input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr,
               RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0
    );

endinterface

// File: rtl/processor_controller_instr_fields.sv
// Purely combinational split of an instruction word into its fields.
module instr_fields
    import proc_pkg::*;
(
    input  logic [IR_W-1:0]      ir_i,
    output logic [3:0]           op_o,
    output logic [RF_ADDR_W-1:0] ra_o,
    output logic [RF_ADDR_W-1:0] rb_o,
    output logic [RF_ADDR_W-1:0] rw_o,
    output logic [D_ADDR_W-1:0]  daddr_o
);

    assign op_o    = ir_i[OP_MSB:OP_LSB];
    assign ra_o    = ir_i[RA_MSB:RA_LSB];
    assign rb_o    = ir_i[RB_MSB:RB_LSB];
    assign rw_o    = ir_i[RW_MSB:RW_LSB];
    assign daddr_o = ir_i[DA_MSB:DA_LSB];

endmodule

// File: rtl/processor_controller.sv
// Moore control unit sequencing fetch/decode/execute for the 16-bit
// processor datapath. Only the state register is clocked; every output is
// decoded from the current state and the IR fields.
module processor_controller
    import proc_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    proc_ctrl_if.master        ctrl,
    output logic [STATE_W-1:0] StateO
);

    state_t               state_q;
    state_t               state_d;
    logic [3:0]           op;
    logic [RF_ADDR_W-1:0] ra;
    logic [RF_ADDR_W-1:0] rb;
    logic [RF_ADDR_W-1:0] rw;
    logic [D_ADDR_W-1:0]  daddr;

    instr_fields u_fields (
        .ir_i    (ctrl.IR),
        .op_o    (op),
        .ra_o    (ra),
        .rb_o    (rb),
        .rw_o    (rw),
        .daddr_o (daddr)
    );

    assign StateO = state_q;

    // State register; reset forces Init immediately, so outputs drop at once
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused codes recover to Init
    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOADA;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_NOOP:   state_d = S_FETCH;
            S_LOADA:  state_d = S_LOADB;
            S_LOADB:  state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_ADD:    state_d = S_FETCH;
            S_SUB:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // Output decode; anything not driven for a state stays 0
    always_comb begin
        ctrl.PC_Clr     = 1'b0;
        ctrl.PC_Up      = 1'b0;
        ctrl.IR_Ld      = 1'b0;
        ctrl.D_Addr     = '0;
        ctrl.D_Wr       = 1'b0;
        ctrl.RF_s       = 1'b0;
        ctrl.RF_W_Addr  = '0;
        ctrl.RF_W_en    = 1'b0;
        ctrl.RF_Ra_Addr = '0;
        ctrl.RF_Rb_Addr = '0;
        ctrl.ALU_s0     = ALU_PASS;
        case (state_q)
            S_INIT: ctrl.PC_Clr = 1'b1;
            S_FETCH: begin
                ctrl.IR_Ld = 1'b1;
                ctrl.PC_Up = 1'b1;
            end
            // LoadA waits out the synchronous memory read; LoadB commits it
            S_LOADA, S_LOADB: begin
                ctrl.D_Addr    = daddr;
                ctrl.RF_s      = 1'b1;
                ctrl.RF_W_Addr = ra;
                ctrl.RF_W_en   = (state_q == S_LOADB);
            end
            S_STORE: begin
                ctrl.D_Addr     = daddr;
                ctrl.RF_Ra_Addr = ra;
                ctrl.D_Wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                ctrl.RF_Ra_Addr = ra;
                ctrl.RF_Rb_Addr = rb;
                ctrl.RF_W_Addr  = rw;
                ctrl.ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
                ctrl.RF_W_en    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_processor_controller.sv
// Directed bench for processor_controller: walks reset, each opcode,
// illegal opcode, halt and asynchronous reset, checking every output.
module tb_processor_controller;
    import proc_pkg::*;

    logic       Clk;
    logic       Reset;
    logic [3:0] state_o;
    int         total;
    int         bad;
    logic       mon_on;
    logic       watch_wen;
    int         wen_pulses;

    proc_ctrl_if bus ();

    processor_controller dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .ctrl   (bus.master),
        .StateO (state_o)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Mutual-exclusion properties on every sampled cycle
    always @(negedge Clk) begin
        if (mon_on) begin
            total++;
            if ((bus.RF_W_en & bus.D_Wr) !== 1'b0) begin
                bad++;
                $display("FAIL wen_dwr_excl: RF_W_en=%b D_Wr=%b state=%0d", bus.RF_W_en, bus.D_Wr, state_o);
            end
            total++;
            if ((bus.PC_Clr & bus.PC_Up) !== 1'b0) begin
                bad++;
                $display("FAIL pc_excl: PC_Clr=%b PC_Up=%b state=%0d", bus.PC_Clr, bus.PC_Up, state_o);
            end
        end
    end

    // Counts any RF write-enable pulse while armed
    always @(posedge bus.RF_W_en) begin
        if (watch_wen) wen_pulses++;
    end

    task automatic test_reset();
        int exp_s[7] = '{0, 1, 2, 3, 1, 2, 3};
        bus.IR = 16'h0000;
        Reset = 1'b0;
        #1 Reset = 1'b1;
        #1;
        total++;
        if (state_o !== 4'd0 || bus.PC_Clr !== 1'b1 || bus.PC_Up !== 1'b0 || bus.IR_Ld !== 1'b0 ||
            bus.D_Wr !== 1'b0 || bus.RF_W_en !== 1'b0 || bus.D_Addr !== 8'h00 || bus.ALU_s0 !== 3'd0) begin
            bad++;
            $display("FAIL reset_values: state=%0d PC_Clr=%b PC_Up=%b IR_Ld=%b D_Wr=%b W_en=%b want 0/1/0/0/0/0",
                     state_o, bus.PC_Clr, bus.PC_Up, bus.IR_Ld, bus.D_Wr, bus.RF_W_en);
        end
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        mon_on = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge Clk);
            total++;
            if (state_o !== exp_s[i][3:0]) begin
                bad++;
                $display("FAIL reset_seq[%0d]: state=%0d want %0d", i, state_o, exp_s[i]);
            end
            total++;
            if (bus.PC_Up !== (exp_s[i] == 1) || bus.IR_Ld !== (exp_s[i] == 1) || bus.PC_Clr !== (exp_s[i] == 0)) begin
                bad++;
                $display("FAIL reset_seq_pc[%0d]: PC_Up=%b IR_Ld=%b PC_Clr=%b in state %0d",
                         i, bus.PC_Up, bus.IR_Ld, bus.PC_Clr, exp_s[i]);
            end
        end
    endtask

    task automatic test_load();
        int exp_s[5] = '{1, 2, 4, 5, 1};
        bus.IR = 16'h231B;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            total++;
            if (state_o !== exp_s[i][3:0]) begin
                bad++;
                $display("FAIL load_seq[%0d]: state=%0d want %0d", i, state_o, exp_s[i]);
            end
            if (exp_s[i] == 4 || exp_s[i] == 5) begin
                total++;
                if (bus.D_Addr !== 8'h1B || bus.RF_s !== 1'b1 || bus.RF_W_Addr !== 4'd3 ||
                    bus.RF_W_en !== (exp_s[i] == 5) || bus.D_Wr !== 1'b0) begin
                    bad++;
                    $display("FAIL load_out[%0d]: D_Addr=%h RF_s=%b W_Addr=%0d W_en=%b D_Wr=%b want 1b/1/3/%0d/0",
                             i, bus.D_Addr, bus.RF_s, bus.RF_W_Addr, bus.RF_W_en, bus.D_Wr, exp_s[i] == 5);
                end
            end else begin
                total++;
                if (bus.RF_W_en !== 1'b0 || bus.RF_s !== 1'b0) begin
                    bad++;
                    $display("FAIL load_idle[%0d]: W_en=%b RF_s=%b want 0/0", i, bus.RF_W_en, bus.RF_s);
                end
            end
        end
    endtask

    task automatic test_add_sub();
        int exp_s[6] = '{2, 7, 1, 2, 8, 1};
        int wen_cnt = 0;
        bus.IR = 16'h3125;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (bus.RF_W_en === 1'b1) wen_cnt++;
            total++;
            if (state_o !== exp_s[i][3:0]) begin
                bad++;
                $display("FAIL addsub_seq[%0d]: state=%0d want %0d", i, state_o, exp_s[i]);
            end
            if (exp_s[i] == 7 || exp_s[i] == 8) begin
                total++;
                if (bus.RF_Ra_Addr !== 4'd1 || bus.RF_Rb_Addr !== 4'd2 || bus.RF_W_Addr !== 4'd5 ||
                    bus.RF_W_en !== 1'b1 || bus.RF_s !== 1'b0 || bus.D_Wr !== 1'b0 ||
                    bus.ALU_s0 !== ((exp_s[i] == 7) ? 3'd1 : 3'd2)) begin
                    bad++;
                    $display("FAIL addsub_out[%0d]: Ra=%0d Rb=%0d W=%0d W_en=%b RF_s=%b ALU=%0d want 1/2/5/1/0/%0d",
                             i, bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.RF_W_Addr, bus.RF_W_en, bus.RF_s,
                             bus.ALU_s0, (exp_s[i] == 7) ? 1 : 2);
                end
            end
            if (i == 2) bus.IR = 16'h4125;
        end
        total++;
        if (wen_cnt !== 2) begin
            bad++;
            $display("FAIL addsub_wen_count: cycles=%0d want 2", wen_cnt);
        end
    endtask

    task automatic test_store_illegal();
        int exp_s[6] = '{2, 6, 1, 2, 3, 1};
        int wr_cnt = 0;
        bus.IR = 16'h1780;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (bus.D_Wr === 1'b1) wr_cnt++;
            total++;
            if (state_o !== exp_s[i][3:0]) begin
                bad++;
                $display("FAIL store_seq[%0d]: state=%0d want %0d", i, state_o, exp_s[i]);
            end
            if (exp_s[i] == 6) begin
                total++;
                if (bus.D_Addr !== 8'h80 || bus.RF_Ra_Addr !== 4'd7 || bus.D_Wr !== 1'b1 || bus.RF_W_en !== 1'b0) begin
                    bad++;
                    $display("FAIL store_out: D_Addr=%h Ra=%0d D_Wr=%b W_en=%b want 80/7/1/0",
                             bus.D_Addr, bus.RF_Ra_Addr, bus.D_Wr, bus.RF_W_en);
                end
            end
            if (i == 2) bus.IR = 16'hF000;
        end
        total++;
        if (wr_cnt !== 1) begin
            bad++;
            $display("FAIL store_wr_count: cycles=%0d want 1", wr_cnt);
        end
    endtask

    task automatic test_halt();
        bus.IR = 16'h5000;
        @(negedge Clk);
        @(negedge Clk);
        total++;
        if (state_o !== 4'd9) begin
            bad++;
            $display("FAIL halt_enter: state=%0d want 9", state_o);
        end
        for (int i = 0; i < 20; i++) begin
            bus.IR = (i % 2 == 0) ? 16'h3125 : 16'h5000;
            @(negedge Clk);
            total++;
            if (state_o !== 4'd9 || bus.PC_Clr !== 1'b0 || bus.PC_Up !== 1'b0 || bus.IR_Ld !== 1'b0 ||
                bus.D_Wr !== 1'b0 || bus.RF_W_en !== 1'b0 || bus.D_Addr !== 8'h00 || bus.ALU_s0 !== 3'd0) begin
                bad++;
                $display("FAIL halt_hold[%0d]: state=%0d PC_Clr=%b PC_Up=%b IR_Ld=%b D_Wr=%b W_en=%b ALU=%0d want 9 all 0",
                         i, state_o, bus.PC_Clr, bus.PC_Up, bus.IR_Ld, bus.D_Wr, bus.RF_W_en, bus.ALU_s0);
            end
        end
        #2 Reset = 1'b1;
        #1;
        total++;
        if (state_o !== 4'd0 || bus.PC_Clr !== 1'b1) begin
            bad++;
            $display("FAIL halt_reset_async: state=%0d PC_Clr=%b want 0/1", state_o, bus.PC_Clr);
        end
        @(negedge Clk);
        Reset = 1'b0;
        total++;
        if (state_o !== 4'd0) begin
            bad++;
            $display("FAIL halt_reset_hold: state=%0d want 0", state_o);
        end
        bus.IR = 16'h231B;
        @(negedge Clk);
        total++;
        if (state_o !== 4'd1) begin
            bad++;
            $display("FAIL halt_resume: state=%0d want 1", state_o);
        end
    endtask

    task automatic test_async_reset();
        wen_pulses = 0;
        watch_wen = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        total++;
        if (state_o !== 4'd4 || bus.D_Addr !== 8'h1B) begin
            bad++;
            $display("FAIL async_in_loada: state=%0d D_Addr=%h want 4/1b", state_o, bus.D_Addr);
        end
        #2 Reset = 1'b1;
        #1;
        total++;
        if (state_o !== 4'd0 || bus.D_Addr !== 8'h00 || bus.RF_W_en !== 1'b0 || bus.RF_s !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_now: state=%0d D_Addr=%h W_en=%b RF_s=%b want 0/00/0/0",
                     state_o, bus.D_Addr, bus.RF_W_en, bus.RF_s);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            total++;
            if (state_o !== 4'd0 || bus.RF_W_en !== 1'b0 || bus.D_Wr !== 1'b0) begin
                bad++;
                $display("FAIL async_reset_hold[%0d]: state=%0d W_en=%b D_Wr=%b want 0/0/0",
                         i, state_o, bus.RF_W_en, bus.D_Wr);
            end
        end
        Reset = 1'b0;
        @(negedge Clk);
        total++;
        if (state_o !== 4'd1) begin
            bad++;
            $display("FAIL async_resume: state=%0d want 1", state_o);
        end
        watch_wen = 1'b0;
        total++;
        if (wen_pulses !== 0) begin
            bad++;
            $display("FAIL async_no_wen: pulses=%0d want 0", wen_pulses);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        mon_on = 1'b0;
        watch_wen = 1'b0;
        wen_pulses = 0;
        Reset = 1'b0;
        bus.IR = 16'h0000;
        test_reset();
        test_load();
        test_add_sub();
        test_store_illegal();
        test_halt();
        test_async_reset();
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/processor_controller.md
Name: processor_controller

Overview:
- Moore control unit that sequences the 16-bit programmable processor datapath: program counter, instruction register, data memory, 16x16 register file, ALU and register-file write mux.
- Runs a fetch/decode/execute loop and drives every datapath select and enable.
- Exports its current state as StateO for bench monitoring.
- Instances alongside the datapath inside Processor.

Parameters:
- IR_W, 16, instruction width.
- D_ADDR_W, 8, data-memory address width.
- RF_ADDR_W, 4, register-file address width.
- ALU_SEL_W, 3, ALU function-select width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; forces Init.
- IR  in  IR_W  current instruction-register contents.
- PC_Clr  out  1  clear program counter to 0.
- PC_Up  out  1  increment program counter; the counter wraps 31->0.
- IR_Ld  out  1  load IR from instruction memory at PC.
- D_Addr  out  D_ADDR_W  data-memory address.
- D_Wr  out  1  data-memory write enable.
- RF_s  out  1  RF write-mux select: 1 = memory read data, 0 = ALU output.
- RF_W_Addr  out  RF_ADDR_W  RF write address.
- RF_W_en  out  1  RF write enable.
- RF_Ra_Addr  out  RF_ADDR_W  RF read port A address.
- RF_Rb_Addr  out  RF_ADDR_W  RF read port B address.
- ALU_s0  out  ALU_SEL_W  ALU function: 0 = pass A, 1 = A+B, 2 = A-B.
- StateO  out  4  current state encoding.

Behaviour:
- Single clock domain (Clk). Reset is asynchronous and active-high. Only the state register is clocked.
- All outputs are a combinational function of the current state and IR fields. Outputs not listed for a state are 0.
- Instruction fields: op = IR[15:12].

Opcodes:
- 0 NOOP.
- 1 STORE: D[IR[7:0]] <= RF[IR[11:8]].
- 2 LOAD: RF[IR[11:8]] <= D[IR[7:0]].
- 3 ADD: RF[IR[3:0]] <= RF[IR[11:8]] + RF[IR[7:4]].
- 4 SUB: same operands and destination as ADD, subtract.
- 5 HALT.
- 6-15 are executed as NOOP.

States (StateO encoding):
- Init 0
- Fetch 1
- Decode 2
- Noop 3
- LoadA 4
- LoadB 5
- Store 6
- Add 7
- Sub 8
- Halt 9
- Codes 10-15 are unreachable; if entered, next state is Init.

Transitions and outputs per state:
- Init: PC_Clr=1 -> Fetch.
- Fetch: IR_Ld=1, PC_Up=1 -> Decode. The PC increments in the same edge that loads IR.
- Decode: no outputs. Next state by op: Noop, Store, LoadA, Add, Sub or Halt; illegal op -> Noop.
- Noop: -> Fetch.
- LoadA: D_Addr=IR[7:0], RF_s=1, RF_W_Addr=IR[11:8] -> LoadB. Covers the one-cycle synchronous memory read latency.
- LoadB: as LoadA, plus RF_W_en=1 -> Fetch.
- Store: D_Addr=IR[7:0], RF_Ra_Addr=IR[11:8], D_Wr=1 -> Fetch.
- Add: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], ALU_s0=1, RF_s=0, RF_W_en=1 -> Fetch.
- Sub: as Add, with ALU_s0=2 -> Fetch.
- Halt: all outputs 0. Stays in Halt regardless of IR; only Reset leaves it.

Timing and boundary conditions:
- Latency in cycles, Fetch to next Fetch: NOOP 3, STORE/ADD/SUB 3, LOAD 4.
- Reset values: state Init, StateO=0, PC_Clr=1, all other outputs 0.
- Reset asserted mid-instruction (e.g. LoadA or Store) takes effect immediately, without waiting for Clk: D_Wr and RF_W_en drop to 0 in the same instant, and no partial write is committed at the next edge.
- Reset released: Init is held for the first edge, then Fetch.
- IR changing outside Fetch is legal: outputs follow IR combinationally. The datapath guarantees IR is stable except on IR_Ld.
- RF_W_en and D_Wr are never both 1 in the same state.
- At most one of PC_Clr and PC_Up is asserted at any time.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants OP_NOOP..OP_HALT;
  - state encodings S_INIT..S_HALT (4 bits);
  - ALU select codes ALU_PASS=0, ALU_ADD=1, ALU_SUB=2;
  - field bit positions.
- One natural sub-module, instr_fields: purely combinational extraction of op, ra, rb, rw and daddr from IR, reusable by the datapath and the bench.
- The state register, next-state logic and output decode stay in processor_controller.

Test Plan:
- Reset high for one edge, IR=16'h0000 -> StateO sequence 0,1,2,3,1,2,3; PC_Up=1 and IR_Ld=1 only in state 1; PC_Clr=1 only in state 0.
- IR=16'h231B (LOAD) -> states 1,2,4,5,1. D_Addr=8'h1B and RF_s=1 in states 4 and 5; RF_W_Addr=3; RF_W_en=1 only in state 5.
- IR=16'h3125 (ADD), then 16'h4125 (SUB) -> state 7 then 8, each with Ra=1, Rb=2, W=5, RF_W_en=1 for exactly one cycle. ALU_s0=1 in state 7, 2 in state 8; RF_s=0.
- IR=16'h1780 (STORE) -> state 6 with D_Addr=8'h80, RF_Ra_Addr=7, D_Wr=1 for one cycle, RF_W_en=0. Then IR=16'hF000 -> Decode goes to Noop (state 3).
- IR=16'h5000 (HALT) -> StateO=9 held for 20 cycles while IR is toggled to 16'h3125; no enables assert. Reset pulse -> StateO=0 at once, then resumes Fetch.
- Reset asserted asynchronously mid-cycle while in LoadA -> StateO=0 and D_Addr=0 before the next Clk edge; RF_W_en never pulses.
